// File: rtl/ntt_job_scheduler.sv
// Round-robin owner of one shared NTT core: grants a requester, streams its N_COEF coefficients into the core, then holds o_done until acked.
// Grant one cycle after requests are seen, core load data one cycle behind each read address; a stalled transform is aborted by a watchdog.
module ntt_job_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int N_COEF  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_req_intt,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_rd_en,
  output logic [7:0]                o_rd_addr,
  input  logic signed [15:0]        i_rd_data,
  output logic                      o_ntt_ready,
  output logic signed [15:0]        o_ntt_data,
  output logic                      o_ntt_intt,
  output logic                      o_ntt_rst,
  input  logic                      i_ntt_valid,
  output logic                      o_done,
  output logic [2:0]                o_done_id,
  input  logic                      i_done_ack,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] LAST_ADDR = 8'(N_COEF - 1);
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    RUN    = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [7:0]        wd_cnt;
  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic [NUM_REQ-1:0] win_oh;

  // Walk from furthest to nearest so the requester closest after ptr wins.
  always_comb begin
    int idx;
    logic [PW-1:0] sel;
    win_vld = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    idx     = 0;
    sel     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      sel = idx[PW-1:0];
      if (i_req[sel]) begin
        win_vld     = 1'b1;
        win_idx     = sel;
        win_oh      = '0;
        win_oh[sel] = 1'b1;
      end
    end
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= PW'(NUM_REQ - 1);
      wd_cnt      <= '0;
      o_gnt       <= '0;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= '0;
      o_ntt_ready <= 1'b0;
      o_ntt_data  <= '0;
      o_ntt_intt  <= 1'b0;
      o_ntt_rst   <= 1'b1;
      o_done      <= 1'b0;
      o_done_id   <= '0;
      o_err       <= 1'b0;
    end else begin
      // i_rd_data answers the address of the current cycle and is captured at its closing edge.
      o_ntt_ready <= o_rd_en;
      o_ntt_data  <= o_rd_en ? i_rd_data : '0;
      o_ntt_rst   <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state      <= LOAD;
            o_gnt      <= win_oh;
            ptr        <= win_idx;
            o_ntt_intt <= i_req_intt[win_idx];
            o_rd_en    <= 1'b1;
            o_rd_addr  <= '0;
          end
        end
        LOAD: begin
          if (o_rd_addr == LAST_ADDR) begin
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
            state     <= DRAIN;
          end else begin
            o_rd_addr <= o_rd_addr + 8'd1;
          end
        end
        DRAIN: begin
          wd_cnt <= '0;
          state  <= RUN;
        end
        RUN: begin
          if (i_ntt_valid) begin
            state     <= RESULT;
            o_done    <= 1'b1;
            o_done_id <= 3'(ptr);
          end else if (wd_cnt == WD_LAST) begin
            state     <= IDLE;
            o_err     <= 1'b1;
            o_ntt_rst <= 1'b1;
            o_gnt     <= '0;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        RESULT: begin
          if (i_done_ack) begin
            state     <= IDLE;
            o_done    <= 1'b0;
            o_done_id <= '0;
            o_gnt     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Scoreboard bench: stimulus queues the expected grant/data/done/release/reset events with their cycle stamps; a negedge monitor pops and compares.
module tb_ntt_job_scheduler;

  localparam int NREQ = 3;
  localparam int NC   = 256;
  localparam int TO   = 50;

  localparam int K_GNT  = 0;
  localparam int K_DAT  = 1;
  localparam int K_DONE = 2;
  localparam int K_GDN  = 3;
  localparam int K_RST  = 4;

  logic              i_clk;
  logic              i_rst_n;
  logic [NREQ-1:0]   i_req;
  logic [NREQ-1:0]   i_req_intt;
  logic [NREQ-1:0]   o_gnt;
  logic              o_rd_en;
  logic [7:0]        o_rd_addr;
  logic signed [15:0] i_rd_data;
  logic              o_ntt_ready;
  logic signed [15:0] o_ntt_data;
  logic              o_ntt_intt;
  logic              o_ntt_rst;
  logic              i_ntt_valid;
  logic              o_done;
  logic [2:0]        o_done_id;
  logic              i_done_ack;
  logic              o_busy;
  logic              o_err;

  ntt_job_scheduler #(.NUM_REQ(NREQ), .N_COEF(NC), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_req_intt(i_req_intt),
    .o_gnt(o_gnt), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_ntt_ready(o_ntt_ready), .o_ntt_data(o_ntt_data), .o_ntt_intt(o_ntt_intt),
    .o_ntt_rst(o_ntt_rst), .i_ntt_valid(i_ntt_valid), .o_done(o_done),
    .o_done_id(o_done_id), .i_done_ack(i_done_ack), .o_busy(o_busy), .o_err(o_err)
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] val;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  logic [NREQ-1:0] prev_gnt = '0;
  logic            prev_done = 1'b0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Each requester's buffer holds base+address; the buffer answers combinationally.
  function automatic int base_of(input int idx);
    case (idx)
      0:       return -500;
      1:       return 100;
      2:       return 3000;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    int b;
    b = 0;
    if (o_gnt == 3'b001) b = base_of(0);
    else if (o_gnt == 3'b010) b = base_of(1);
    else if (o_gnt == 3'b100) b = base_of(2);
    i_rd_data = 16'(b + int'(o_rd_addr));
  end

  function automatic string kname(input int k);
    case (k)
      K_GNT:   return "grant";
      K_DAT:   return "core_data";
      K_DONE:  return "done";
      K_GDN:   return "release";
      K_RST:   return "core_reset";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int kind, input int c, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic check(input int kind, input logic [15:0] val);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got val=%h, required no event", kname(kind), cyc, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
        miscompares++;
        $display("FAIL %s: got %s val=%h at cycle %0d, required %s val=%h at cycle %0d",
                 kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (cyc >= 1) begin
      if (o_gnt != '0 && prev_gnt == '0)
        check(K_GNT, {3'b0, o_ntt_intt, o_gnt, o_rd_en, o_rd_addr});
      if (o_ntt_ready)
        check(K_DAT, o_ntt_data);
      if (o_done && !prev_done)
        check(K_DONE, {9'b0, o_done_id, o_gnt, o_busy});
      if (o_gnt == '0 && prev_gnt != '0 && !o_ntt_rst)
        check(K_GDN, {13'b0, o_done, o_busy, o_rd_en});
      if (o_ntt_rst || o_err)
        check(K_RST, {o_err, o_gnt, o_done, o_done_id, o_rd_en, o_ntt_ready, o_busy, o_ntt_intt, o_ntt_rst, 3'b0});
      prev_gnt  = o_gnt;
      prev_done = o_done;
    end
  end

  task automatic wait_until(input int k);
    while (cyc < k) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Requests are already driven in cycle c: grant lands at c+1, coefficient a reaches the core at c+2+a.
  task automatic expect_load(input int c, input int idx, input logic intt, input int n_dat);
    logic [2:0] g;
    g = 3'b001 << idx;
    push(K_GNT, c + 1, {3'b0, intt, g, 1'b1, 8'd0});
    for (int a = 0; a < n_dat; a++)
      push(K_DAT, c + 2 + a, 16'(base_of(idx) + a));
  endtask

  task automatic valid_pulse(input int k, input int idx);
    logic [2:0] g;
    g = 3'b001 << idx;
    push(K_DONE, k + 1, {9'b0, 3'(idx), g, 1'b1});
    wait_until(k);
    i_ntt_valid = 1'b1;
    wait_until(k + 1);
    i_ntt_valid = 1'b0;
  endtask

  task automatic ack_pulse(input int k);
    push(K_GDN, k + 1, 16'h0000);
    wait_until(k);
    i_done_ack = 1'b1;
    wait_until(k + 1);
    i_done_ack = 1'b0;
  endtask

  initial begin
    int c;
    int c2;
    logic [2:0] rr_intt;
    i_rst_n     = 1'b0;
    i_req       = '0;
    i_req_intt  = '0;
    i_ntt_valid = 1'b0;
    i_done_ack  = 1'b0;

    // Reset held for two edges: core reset high, everything else low.
    push(K_RST, 1, 16'h0008);
    push(K_RST, 2, 16'h0008);
    wait_until(2);
    i_rst_n = 1'b1;

    // Round-robin with all three requesting, each result acked at once.
    rr_intt    = 3'b101;
    c          = 5;
    wait_until(c);
    i_req      = 3'b111;
    i_req_intt = rr_intt;
    for (int j = 0; j < 4; j++) begin
      expect_load(c, j % 3, rr_intt[j % 3], NC);
      if (j == 3) begin
        wait_until(c + 1);
        i_req = '0;
      end
      valid_pulse(c + 260, j % 3);
      ack_pulse(c + 261);
      c = c + 262;
    end

    // Single job from requester 1: done one cycle after core valid, release one cycle after ack.
    c = 1060;
    wait_until(c);
    i_req      = 3'b010;
    i_req_intt = 3'b000;
    expect_load(c, 1, 1'b0, NC);
    wait_until(c + 1);
    i_req = '0;
    valid_pulse(c + 300, 1);
    ack_pulse(c + 305);

    // Request dropped in LOAD, stray valid in LOAD, stray ack in RUN: job still completes normally.
    c = 1370;
    wait_until(c);
    i_req      = 3'b001;
    i_req_intt = 3'b001;
    expect_load(c, 0, 1'b1, NC);
    wait_until(c + 10);
    i_req = '0;
    wait_until(c + 50);
    i_ntt_valid = 1'b1;
    wait_until(c + 51);
    i_ntt_valid = 1'b0;
    wait_until(c + 270);
    i_done_ack = 1'b1;
    wait_until(c + 271);
    i_done_ack = 1'b0;
    valid_pulse(c + 280, 0);
    ack_pulse(c + 283);

    // Back-to-back: new request arrives with the ack, one IDLE cycle, then granted.
    c = 1660;
    wait_until(c);
    i_req      = 3'b100;
    i_req_intt = 3'b000;
    expect_load(c, 2, 1'b0, NC);
    wait_until(c + 1);
    i_req = '0;
    valid_pulse(c + 260, 2);
    push(K_GDN, c + 264, 16'h0000);
    expect_load(c + 264, 0, 1'b1, NC);
    wait_until(c + 263);
    i_done_ack = 1'b1;
    i_req      = 3'b001;
    i_req_intt = 3'b001;
    wait_until(c + 264);
    i_done_ack = 1'b0;
    c2 = c + 264;
    wait_until(c2 + 1);
    i_req = '0;
    valid_pulse(c2 + 258, 0);
    ack_pulse(c2 + 259);

    // Watchdog: RUN entered at c+258, abort pulse TO cycles later, direction flag still held.
    c = 2190;
    wait_until(c);
    i_req      = 3'b010;
    i_req_intt = 3'b010;
    expect_load(c, 1, 1'b1, NC);
    push(K_RST, c + 258 + TO, 16'h8018);
    wait_until(c + 1);
    i_req = '0;
    wait_until(c + 258 + TO + 12);

    // Reset while address 77 is on the bus, then a fresh load from address 0.
    c = 2512;
    wait_until(c);
    i_req      = 3'b100;
    i_req_intt = 3'b000;
    expect_load(c, 2, 1'b0, 77);
    push(K_RST, c + 79, 16'h0008);
    wait_until(c + 1);
    i_req = '0;
    wait_until(c + 78);
    i_rst_n = 1'b0;
    wait_until(c + 79);
    i_rst_n = 1'b1;
    c2 = c + 80;
    wait_until(c2);
    i_req = 3'b100;
    expect_load(c2, 2, 1'b0, NC);
    wait_until(c2 + 1);
    i_req = '0;
    valid_pulse(c2 + 258, 2);
    ack_pulse(c2 + 259);
    wait_until(c2 + 270);

    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s never seen: required val=%h at cycle %0d", kname(e.kind), e.val, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
